irq_pending_latch: RTL and testbench

//  Upstream front end for the 4-input priority encoder. Synchronises raw

---
 rtl/irq_pending_latch.sv | 99 +++++++++
 tb/tb_irq_pending_latch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// Request front end for the 4-input priority encoder: synchronises raw request
// lines, latches them as sticky pending bits until serviced, and counts re-requests.
module irq_pending_latch #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int OVF_W       = 4,
  parameter int ID_W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_raw,
  input  logic [N-1:0]       edge_mode,
  input  logic [N-1:0]       mask,
  input  logic               svc_valid,
  input  logic [ID_W-1:0]    svc_id,
  output logic [N-1:0]       pending,
  output logic               pend_any,
  output logic [N-1:0]       ovf_flag,
  output logic [N*OVF_W-1:0] ovf_cnt
);

  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     sync_d;
  logic [N-1:0]     pend_reg;
  logic [OVF_W-1:0] cnt_q [N];

  logic [N-1:0] s;
  logic [N-1:0] rise;
  logic [N-1:0] set;
  logic [N-1:0] clr;
  logic [N-1:0] ovf_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      sync_d <= '0;
    end else begin
      sync_q[0] <= req_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      sync_d <= s;
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = s & ~sync_d;
  assign set    = (edge_mode & rise) | (~edge_mode & s);
  assign ovf_ev = edge_mode & rise & pend_reg & ~clr;

  // Out-of-range ids match no line, so they clear nothing.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = svc_valid && (int'(svc_id) == i);
    end
  end

  // Set has priority over clear so a request arriving during service survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= set | (pend_reg & ~clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr[i]) begin
          ovf_flag[i] <= 1'b0;
          cnt_q[i]    <= '0;
        end else if (ovf_ev[i]) begin
          ovf_flag[i] <= 1'b1;
          if (cnt_q[i] != {OVF_W{1'b1}}) begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt_pack
    assign ovf_cnt[g*OVF_W +: OVF_W] = cnt_q[g];
  end

  // Mask hides lines from the encoder only; the latch and counters keep running.
  assign pending  = pend_reg & ~mask;
  assign pend_any = |pending;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed self-checking bench for irq_pending_latch with hand-computed
// expectations for latency, service, set-vs-clear, saturation, mask and reset.
module tb_irq_pending_latch;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_raw;
  logic [3:0]  edge_mode;
  logic [3:0]  mask;
  logic        svc_valid;
  logic [1:0]  svc_id;
  logic [3:0]  pending;
  logic        pend_any;
  logic [3:0]  ovf_flag;
  logic [15:0] ovf_cnt;

  int compared   = 0;
  int mismatched = 0;

  irq_pending_latch #(
    .N(4),
    .SYNC_STAGES(2),
    .OVF_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_raw(req_raw),
    .edge_mode(edge_mode),
    .mask(mask),
    .svc_valid(svc_valid),
    .svc_id(svc_id),
    .pending(pending),
    .pend_any(pend_any),
    .ovf_flag(ovf_flag),
    .ovf_cnt(ovf_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives all inputs just after an edge, then advances the given number of edges.
  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] emode,
                               input logic [3:0] msk, input logic sv,
                               input logic [1:0] sid, input int cycles);
    req_raw   = req;
    edge_mode = emode;
    mask      = msk;
    svc_valid = sv;
    svc_id    = sid;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_raw   = '0;
    edge_mode = 4'hF;
    mask      = '0;
    svc_valid = 1'b0;
    svc_id    = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_pending", 32'(pending), 32'h0);
    checkOutput("reset_pend_any", 32'(pend_any), 32'h0);
    checkOutput("reset_ovf_cnt", 32'(ovf_cnt), 32'h0);
    checkOutput("reset_ovf_flag", 32'(ovf_flag), 32'h0);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b0, 2'd0, 2);

    // Edge latency on line 2
    applyStimulus(4'b0100, 4'hF, 4'h0, 1'b0, 2'd0, 2);
    checkOutput("latency_edge2", 32'(pending), 32'h0);
    applyStimulus(4'b0100, 4'hF, 4'h0, 1'b0, 2'd0, 1);
    checkOutput("latency_edge3", 32'(pending), 32'b0100);
    checkOutput("latency_any", 32'(pend_any), 32'h1);
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b0, 2'd0, 3);
    checkOutput("latency_hold", 32'(pending), 32'b0100);

    // Add line 1, then service line 2
    applyStimulus(4'b0010, 4'hF, 4'h0, 1'b0, 2'd0, 3);
    checkOutput("two_pending", 32'(pending), 32'b0110);
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b0, 2'd0, 3);
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b1, 2'd2, 1);
    checkOutput("service_line2", 32'(pending), 32'b0010);
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b0, 2'd0, 1);

    // One re-request on pending line 1 counts an overflow
    applyStimulus(4'b0010, 4'hF, 4'h0, 1'b0, 2'd0, 3);
    checkOutput("ovf1_cnt", 32'(ovf_cnt[7:4]), 32'd1);
    checkOutput("ovf1_flag", 32'(ovf_flag), 32'b0010);
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b0, 2'd0, 3);

    // Rise coinciding with service: stays pending, counter cleared
    applyStimulus(4'b0010, 4'hF, 4'h0, 1'b0, 2'd0, 2);
    applyStimulus(4'b0010, 4'hF, 4'h0, 1'b1, 2'd1, 1);
    checkOutput("setclr_pending", 32'(pending), 32'b0010);
    checkOutput("setclr_cnt", 32'(ovf_cnt[7:4]), 32'd0);
    checkOutput("setclr_flag", 32'(ovf_flag[1]), 32'h0);
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b0, 2'd0, 3);
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b1, 2'd1, 1);
    checkOutput("clear_line1", 32'(pending), 32'h0);

    // Overflow saturation on line 0: one set pulse then 20 re-requests
    applyStimulus(4'b0001, 4'hF, 4'h0, 1'b0, 2'd0, 3);
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b0, 2'd0, 3);
    checkOutput("sat_first", 32'(pending), 32'b0001);
    for (int p = 1; p <= 20; p++) begin
      applyStimulus(4'b0001, 4'hF, 4'h0, 1'b0, 2'd0, 3);
      applyStimulus(4'b0000, 4'hF, 4'h0, 1'b0, 2'd0, 3);
      if (p == 3)  checkOutput("sat_cnt3", 32'(ovf_cnt[3:0]), 32'd3);
      if (p == 15) checkOutput("sat_cnt15", 32'(ovf_cnt[3:0]), 32'd15);
    end
    checkOutput("sat_cnt20", 32'(ovf_cnt[3:0]), 32'd15);
    checkOutput("sat_flag", 32'(ovf_flag), 32'b0001);
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b1, 2'd0, 1);
    checkOutput("sat_clr_pending", 32'(pending), 32'h0);
    checkOutput("sat_clr_cnt", 32'(ovf_cnt), 32'h0);
    checkOutput("sat_clr_flag", 32'(ovf_flag), 32'h0);
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b0, 2'd0, 1);

    // Level mode on masked line 3, then unmask in the same cycle
    applyStimulus(4'b1000, 4'b0111, 4'b1000, 1'b0, 2'd0, 3);
    checkOutput("mask_pending", 32'(pending), 32'h0);
    checkOutput("mask_any", 32'(pend_any), 32'h0);
    mask = 4'b0000;
    #1;
    checkOutput("unmask_pending", 32'(pending), 32'b1000);
    checkOutput("unmask_any", 32'(pend_any), 32'h1);
    applyStimulus(4'b1000, 4'b0111, 4'h0, 1'b1, 2'd3, 1);
    checkOutput("level_repend", 32'(pending), 32'b1000);
    applyStimulus(4'b0000, 4'b0111, 4'h0, 1'b0, 2'd0, 3);
    checkOutput("level_held", 32'(pending), 32'b1000);
    applyStimulus(4'b0000, 4'b0111, 4'h0, 1'b1, 2'd3, 1);
    checkOutput("level_clear", 32'(pending), 32'h0);
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b0, 2'd0, 3);

    // Asynchronous reset mid-activity with pend_reg = 1011 and a live counter
    applyStimulus(4'b1011, 4'hF, 4'h0, 1'b0, 2'd0, 3);
    applyStimulus(4'b0000, 4'hF, 4'h0, 1'b0, 2'd0, 3);
    applyStimulus(4'b0001, 4'hF, 4'h0, 1'b0, 2'd0, 3);
    checkOutput("pre_reset_pending", 32'(pending), 32'b1011);
    checkOutput("pre_reset_cnt0", 32'(ovf_cnt[3:0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_pending", 32'(pending), 32'h0);
    checkOutput("async_reset_any", 32'(pend_any), 32'h0);
    checkOutput("async_reset_cnt", 32'(ovf_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Line 0 held high through release looks like a fresh rising edge
    applyStimulus(4'b0001, 4'hF, 4'h0, 1'b0, 2'd0, 2);
    checkOutput("release_edge2", 32'(pending), 32'h0);
    applyStimulus(4'b0001, 4'hF, 4'h0, 1'b0, 2'd0, 1);
    checkOutput("release_edge3", 32'(pending), 32'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
